// File: rtl/di_uart_host_if.sv
// Signal bundle between the UART/DI bridge and its surroundings: UART byte ports plus the
// DI initiator bus. The bridge uses the master view; the UART and the terminal use slave.
interface di_uart_host_if;
    logic [7:0]  rx_data;
    logic        re;
    logic [7:0]  tx_data;
    logic        we;
    logic        tx_busy;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic        di_read_mode;
    logic        di_read_req;
    logic        di_read;
    logic        di_write_mode;
    logic        di_write;
    logic [15:0] di_reg_datai;
    logic [15:0] di_reg_datao;
    logic        di_read_rdy;
    logic        di_write_rdy;
    logic [15:0] di_transfer_status;

    modport master (
        input  rx_data, re, tx_busy, di_reg_datao, di_read_rdy, di_write_rdy,
               di_transfer_status,
        output tx_data, we, di_term_addr, di_reg_addr, di_read_mode, di_read_req, di_read,
               di_write_mode, di_write, di_reg_datai
    );

    modport slave (
        output rx_data, re, tx_busy, di_reg_datao, di_read_rdy, di_write_rdy,
               di_transfer_status,
        input  tx_data, we, di_term_addr, di_reg_addr, di_read_mode, di_read_req, di_read,
               di_write_mode, di_write, di_reg_datai
    );
endinterface

// File: rtl/di_uart_host.sv
// UART-to-DI command bridge: parses write/read packets from UART RX, runs the DI
// transfers, and returns read data plus the final transfer status over UART TX.
module di_uart_host #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic            ifclk,
    input logic            reset,
    di_uart_host_if.master bus
);
    typedef enum logic [3:0] {
        StIdle, StHdr, StWrData, StWrXfer, StRdReq, StRdWait, StTxLo, StTxHi, StStLo, StStHi
    } state_e;

    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [55:0] hdr_q, hdr_d;
    logic [2:0]  hdr_cnt_q, hdr_cnt_d;
    logic        is_read_q, is_read_d;
    logic        hi_byte_q, hi_byte_d;
    logic        dead_q, dead_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] data_q, data_d;
    logic [15:0] status_q, status_d;
    logic [15:0] term_q, term_d;
    logic [31:0] addr_q, addr_d;
    logic        rd_mode_q, rd_mode_d, wr_mode_q, wr_mode_d;
    logic        rd_req_q, rd_req_d;
    logic        we_q, we_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        counting, hit, tmo, tx_ok, di_read_c, di_write_c;

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        hdr_cnt_d  = hdr_cnt_q;
        is_read_d  = is_read_q;
        hi_byte_d  = hi_byte_q;
        dead_d     = dead_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        status_d   = status_q;
        term_d     = term_q;
        addr_d     = addr_q;
        rd_mode_d  = rd_mode_q;
        wr_mode_d  = wr_mode_q;
        rd_req_d   = 1'b0;
        we_d       = 1'b0;
        tx_data_d  = tx_data_q;
        counting   = 1'b0;
        hit        = 1'b0;
        di_read_c  = 1'b0;
        di_write_c = 1'b0;
        tmo        = (wait_q == TmoLast);
        // One-cycle gap after each we so the UART has time to raise tx_busy.
        tx_ok      = !bus.tx_busy && !we_q;

        unique case (state_q)
            StIdle: begin
                if (bus.re && (bus.rx_data == 8'h01 || bus.rx_data == 8'h02)) begin
                    is_read_d = bus.rx_data[1];
                    hdr_cnt_d = '0;
                    state_d   = StHdr;
                end
            end
            StHdr: begin
                counting = 1'b1;
                if (bus.re) begin
                    hit       = 1'b1;
                    hdr_d     = {hdr_q[47:0], bus.rx_data};
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                    if (hdr_cnt_q == 3'd7) begin
                        term_d    = hdr_q[55:40];
                        addr_d    = hdr_q[39:8];
                        cnt_d     = {hdr_q[7:0], bus.rx_data};
                        hi_byte_d = 1'b0;
                        if (is_read_q) begin
                            rd_mode_d = 1'b1;
                            rd_req_d  = 1'b1;
                            state_d   = StRdReq;
                        end else begin
                            wr_mode_d = 1'b1;
                            state_d   = StWrData;
                        end
                    end
                end else if (tmo) begin
                    state_d = StIdle;
                end
            end
            StWrData: begin
                if (cnt_q == '0) begin
                    status_d  = bus.di_transfer_status;
                    wr_mode_d = 1'b0;
                    state_d   = StStLo;
                end else begin
                    counting = 1'b1;
                    if (bus.re) begin
                        hit = 1'b1;
                        if (!hi_byte_q) begin
                            data_d[7:0] = bus.rx_data;
                            hi_byte_d   = 1'b1;
                        end else begin
                            data_d[15:8] = bus.rx_data;
                            hi_byte_d    = 1'b0;
                            dead_d       = 1'b0;
                            state_d      = StWrXfer;
                        end
                    end else if (tmo) begin
                        wr_mode_d = 1'b0;
                        state_d   = StIdle;
                    end
                end
            end
            StWrXfer: begin
                if (dead_q) begin
                    dead_d = 1'b0;
                    if (cnt_q == '0) begin
                        status_d  = bus.di_transfer_status;
                        wr_mode_d = 1'b0;
                        state_d   = StStLo;
                    end else begin
                        state_d = StWrData;
                    end
                end else begin
                    counting = 1'b1;
                    if (bus.di_write_rdy) begin
                        hit        = 1'b1;
                        di_write_c = 1'b1;
                        dead_d     = 1'b1;
                        addr_d     = addr_q + 32'd1;
                        cnt_d      = cnt_q - 16'd1;
                    end else if (tmo) begin
                        status_d  = 16'hFFFF;
                        wr_mode_d = 1'b0;
                        state_d   = StStLo;
                    end
                end
            end
            StRdReq: begin
                if (cnt_q == '0) begin
                    status_d  = bus.di_transfer_status;
                    rd_mode_d = 1'b0;
                    state_d   = StStLo;
                end else begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                counting = 1'b1;
                if (bus.di_read_rdy) begin
                    hit       = 1'b1;
                    di_read_c = 1'b1;
                    data_d    = bus.di_reg_datao;
                    addr_d    = addr_q + 32'd1;
                    cnt_d     = cnt_q - 16'd1;
                    state_d   = StTxLo;
                end else if (tmo) begin
                    status_d  = 16'hFFFF;
                    rd_mode_d = 1'b0;
                    state_d   = StStLo;
                end
            end
            StTxLo: begin
                if (tx_ok) begin
                    we_d      = 1'b1;
                    tx_data_d = data_q[7:0];
                    state_d   = StTxHi;
                end
            end
            StTxHi: begin
                if (tx_ok) begin
                    we_d      = 1'b1;
                    tx_data_d = data_q[15:8];
                    if (cnt_q == '0) begin
                        status_d  = bus.di_transfer_status;
                        rd_mode_d = 1'b0;
                        state_d   = StStLo;
                    end else begin
                        state_d = StRdWait;
                    end
                end
            end
            StStLo: begin
                if (tx_ok) begin
                    we_d      = 1'b1;
                    tx_data_d = status_q[7:0];
                    state_d   = StStHi;
                end
            end
            StStHi: begin
                if (tx_ok) begin
                    we_d      = 1'b1;
                    tx_data_d = status_q[15:8];
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Timer measures idle cycles within one waiting state; any progress reloads it.
        wait_d = (counting && !hit && state_d == state_q) ? wait_q + 16'd1 : '0;
    end

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            hdr_q     <= '0;
            hdr_cnt_q <= '0;
            is_read_q <= 1'b0;
            hi_byte_q <= 1'b0;
            dead_q    <= 1'b0;
            wait_q    <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            status_q  <= '0;
            term_q    <= '0;
            addr_q    <= '0;
            rd_mode_q <= 1'b0;
            wr_mode_q <= 1'b0;
            rd_req_q  <= 1'b0;
            we_q      <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            hdr_cnt_q <= hdr_cnt_d;
            is_read_q <= is_read_d;
            hi_byte_q <= hi_byte_d;
            dead_q    <= dead_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            status_q  <= status_d;
            term_q    <= term_d;
            addr_q    <= addr_d;
            rd_mode_q <= rd_mode_d;
            wr_mode_q <= wr_mode_d;
            rd_req_q  <= rd_req_d;
            we_q      <= we_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign bus.tx_data       = tx_data_q;
    assign bus.we            = we_q;
    assign bus.di_term_addr  = term_q;
    assign bus.di_reg_addr   = addr_q;
    assign bus.di_read_mode  = rd_mode_q;
    assign bus.di_read_req   = rd_req_q;
    assign bus.di_read       = di_read_c;
    assign bus.di_write_mode = wr_mode_q;
    assign bus.di_write      = di_write_c;
    assign bus.di_reg_datai  = data_q;
endmodule

// File: tb/tb_di_uart_host.sv
// Randomized bench for di_uart_host: packet-level reference model predicts DI transfers
// and UART response bytes; a negedge monitor collects what the bridge actually did.
module tb_di_uart_host;
    localparam int unsigned Timeout = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
        logic [15:0] term;
    } xfer_t;

    logic ifclk = 1'b0;
    logic reset = 1'b1;
    di_uart_host_if bus ();

    di_uart_host #(.TIMEOUT_CYCLES(Timeout)) dut (
        .ifclk (ifclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 ifclk = ~ifclk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] key     = 16'h0;
    int          wr_rdy_mode = 0;   // 0 never ready, 1 random
    int          rd_rdy_mode = 0;   // 0 never ready, 1 random, 2 always ready
    xfer_t       wr_q[$];
    xfer_t       rd_q[$];
    logic [7:0]  tx_q[$];
    logic        prev_we = 1'b0, prev_busy = 1'b0, prev_req = 1'b0;

    // Terminal read data is a keyed function of the register address.
    assign bus.di_reg_datao = bus.di_reg_addr[15:0] ^ key;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        bus.di_write_rdy = 1'b0;
        bus.di_read_rdy  = 1'b0;
        forever begin
            @(posedge ifclk);
            #1;
            bus.di_write_rdy = (wr_rdy_mode == 1) && ($urandom_range(3) != 0);
            bus.di_read_rdy  = (rd_rdy_mode == 2) ||
                               ((rd_rdy_mode == 1) && ($urandom_range(3) != 0));
        end
    end

    always @(negedge ifclk) begin
        xfer_t x;
        if (!reset) begin
            x.addr = bus.di_reg_addr;
            x.term = bus.di_term_addr;
            if (bus.di_write) begin
                x.data = bus.di_reg_datai;
                wr_q.push_back(x);
            end
            if (bus.di_read) begin
                x.data = bus.di_reg_datao;
                rd_q.push_back(x);
            end
            if (bus.we) begin
                tx_q.push_back(bus.tx_data);
                check("we_spacing", {30'b0, prev_we, prev_busy}, 32'd0);
            end
            if (bus.di_read_req) begin
                check("req_pulse", {31'b0, prev_req}, 32'd0);
                check("req_mode", {31'b0, bus.di_read_mode}, 32'd1);
            end
        end
        prev_we   <= bus.we;
        prev_busy <= bus.tx_busy;
        prev_req  <= bus.di_read_req;
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        check({tag, "_we"}, 32'(bus.we), 32'd0);
        check({tag, "_term"}, 32'(bus.di_term_addr), 32'd0);
        check({tag, "_addr"}, bus.di_reg_addr, 32'd0);
        check({tag, "_rd_mode"}, 32'(bus.di_read_mode), 32'd0);
        check({tag, "_rd_req"}, 32'(bus.di_read_req), 32'd0);
        check({tag, "_rd"}, 32'(bus.di_read), 32'd0);
        check({tag, "_wr_mode"}, 32'(bus.di_write_mode), 32'd0);
        check({tag, "_wr"}, 32'(bus.di_write), 32'd0);
        check({tag, "_datai"}, 32'(bus.di_reg_datai), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge ifclk);
        #1;
        bus.rx_data = b;
        bus.re      = 1'b1;
        @(posedge ifclk);
        #1;
        bus.re = 1'b0;
        repeat (gap) @(posedge ifclk);
    endtask

    // rdy_mode for reads: 0 stuck low, 1 random, 2 high from 7 cycles after the header.
    task automatic run_packet(input bit rd, input logic [15:0] term, input logic [31:0] addr,
                              input logic [15:0] len, input int rdy_mode, input bit busy_hold,
                              input logic [15:0] fixed_words[$]);
        logic [7:0]  hdr[$];
        logic [7:0]  exp_tx[$];
        logic [15:0] words[$];
        xfer_t       exp_x[$];
        xfer_t       got_x[$];
        xfer_t       x;
        logic [15:0] st, exp_st, w;
        int          budget;

        key = 16'($urandom);
        st  = 16'($urandom);
        bus.di_transfer_status = st;
        exp_st = st;
        for (int i = 0; i < int'(len); i++) begin
            x.addr = addr + 32'(i);
            x.term = term;
            if (rd) begin
                w = x.addr[15:0] ^ key;
                if (rdy_mode != 0) begin
                    x.data = w;
                    exp_x.push_back(x);
                    exp_tx.push_back(w[7:0]);
                    exp_tx.push_back(w[15:8]);
                end
            end else begin
                w = (i < fixed_words.size()) ? fixed_words[i] : 16'($urandom);
                words.push_back(w);
                x.data = w;
                exp_x.push_back(x);
            end
        end
        if (rd && rdy_mode == 0 && len != 16'd0) exp_st = 16'hFFFF;
        exp_tx.push_back(exp_st[7:0]);
        exp_tx.push_back(exp_st[15:8]);

        wr_q.delete();
        rd_q.delete();
        tx_q.delete();
        rd_rdy_mode = (rd && rdy_mode == 1) ? 1 : 0;
        wr_rdy_mode = rd ? 0 : 1;

        hdr = '{rd ? 8'h02 : 8'h01, term[15:8], term[7:0], addr[31:24], addr[23:16],
                addr[15:8], addr[7:0], len[15:8], len[7:0]};
        foreach (hdr[i]) send_byte(hdr[i], (rd && i == 8) ? 0 : 9);
        if (!rd) begin
            foreach (words[i]) begin
                send_byte(words[i][7:0], 9);
                send_byte(words[i][15:8], 9);
            end
        end
        if (busy_hold) begin
            bus.tx_busy = 1'b1;
            repeat (50) @(posedge ifclk);
            check("busy_hold_tx", tx_q.size(), 0);
            #1;
            bus.tx_busy = 1'b0;
        end
        if (rd && rdy_mode == 2) begin
            repeat (6) @(posedge ifclk);
            rd_rdy_mode = 2;
        end

        budget = 3000;
        while (tx_q.size() < exp_tx.size() && budget > 0) begin
            @(posedge ifclk);
            budget--;
        end
        repeat (20) @(posedge ifclk);
        rd_rdy_mode = 0;
        wr_rdy_mode = 0;

        if (rd) begin
            got_x = rd_q;
            check("rd_count", got_x.size(), exp_x.size());
            check("no_writes", wr_q.size(), 0);
        end else begin
            got_x = wr_q;
            check("wr_count", got_x.size(), exp_x.size());
            check("no_reads", rd_q.size(), 0);
        end
        for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
            check("xfer_addr", got_x[i].addr, exp_x[i].addr);
            check("xfer_data", 32'(got_x[i].data), 32'(exp_x[i].data));
            check("xfer_term", 32'(got_x[i].term), 32'(exp_x[i].term));
        end
        check("tx_count", tx_q.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            check("tx_byte", 32'(tx_q[i]), 32'(exp_tx[i]));
        check("end_rd_mode", 32'(bus.di_read_mode), 32'd0);
        check("end_wr_mode", 32'(bus.di_write_mode), 32'd0);
    endtask

    initial begin
        logic [15:0] none[$];
        logic [15:0] ex_words[$];
        bit          rd;
        logic [31:0] a;

        bus.rx_data = 8'h00;
        bus.re      = 1'b0;
        bus.tx_busy = 1'b0;
        bus.di_transfer_status = 16'h0000;
        repeat (3) @(posedge ifclk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge ifclk);

        // Write example: two words, status 0.
        ex_words = '{16'h1234, 16'h5678};
        run_packet(1'b0, 16'h0005, 32'h0000_0010, 16'd2, 1, 1'b0, ex_words);
        // Read example: rdy after about 7 cycles.
        run_packet(1'b1, 16'h0005, 32'h0000_0020, 16'd1, 2, 1'b0, none);
        // Read with rdy stuck low: data phase aborted, status FFFF.
        run_packet(1'b1, 16'h0003, 32'h0000_0100, 16'd2, 0, 1'b0, none);
        // Read while the transmitter stays busy for 50 cycles.
        run_packet(1'b1, 16'h0009, 32'h0000_0200, 16'd2, 1, 1'b1, none);
        // Zero-length write and read: status only.
        run_packet(1'b0, 16'h0001, 32'h0000_0300, 16'd0, 1, 1'b0, none);
        run_packet(1'b1, 16'h0001, 32'h0000_0300, 16'd0, 1, 1'b0, none);
        // Address wrap.
        run_packet(1'b0, 16'h0002, 32'hFFFF_FFFF, 16'd2, 1, 1'b0, none);

        // Header stall after 4 bytes: discarded silently.
        tx_q.delete();
        send_byte(8'h01, 3);
        send_byte(8'h00, 3);
        send_byte(8'h05, 3);
        send_byte(8'h00, 3);
        repeat (Timeout + 10) @(posedge ifclk);
        check("stall_tx", tx_q.size(), 0);
        check("stall_wr_mode", 32'(bus.di_write_mode), 32'd0);
        check("stall_rd_mode", 32'(bus.di_read_mode), 32'd0);
        run_packet(1'b0, 16'h0004, 32'h0000_0400, 16'd1, 1, 1'b0, none);

        // Reset while a write waits for rdy.
        wr_rdy_mode = 0;
        foreach (ex_words[i]) ex_words[i] = 16'(i);
        send_byte(8'h01, 3);
        send_byte(8'h00, 3);
        send_byte(8'h07, 3);
        for (int i = 0; i < 4; i++) send_byte(8'h11, 3);
        send_byte(8'h00, 3);
        send_byte(8'h02, 3);
        send_byte(8'hAB, 3);
        send_byte(8'hCD, 3);
        check("xfer_wr_mode", 32'(bus.di_write_mode), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(posedge ifclk);
        #1;
        reset = 1'b0;
        run_packet(1'b0, 16'h0006, 32'h0000_0500, 16'd2, 1, 1'b0, none);

        // Random packets, sometimes preceded by a dropped command byte.
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(3) == 0) send_byte(8'($urandom_range(255, 3)), 5);
            rd = 1'($urandom_range(1));
            a  = ($urandom_range(3) == 0) ? 32'hFFFF_FFFE : $urandom;
            run_packet(rd, 16'($urandom), a, 16'($urandom_range(4)),
                       ($urandom_range(5) == 0) ? 0 : 1, 1'b0, none);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end
endmodule
